usb_ep_fifo_switch: RTL and testbench

USB_EP_FIFO_SWITCH -- requirements
Module: usb_ep_fifo_switch

---
 rtl/usb_ep_fifo_switch.sv | 126 ++++++++++++
 tb/tb_usb_ep_fifo_switch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_fifo_switch.sv
// Routes the USB controller's single Tx/Rx FIFO port to one of NUM_EP endpoint
// FIFO pairs, latching the endpoint per transaction and tracking per-transaction counts/errors.
module usb_ep_fifo_switch #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               currEndP,
    input  logic                     xferStart,
    input  logic                     xferEnd,
    input  logic                     TxFifoREn,
    output logic [DATA_W-1:0]        TxFifoData,
    output logic                     TxFifoEmpty,
    input  logic                     RxFifoWEn,
    output logic                     RxFifoFull,
    output logic [NUM_EP-1:0]        epTxREn,
    input  logic [NUM_EP*DATA_W-1:0] epTxData,
    input  logic [NUM_EP-1:0]        epTxEmpty,
    output logic [NUM_EP-1:0]        epRxWEn,
    input  logic [NUM_EP-1:0]        epRxFull,
    output logic [3:0]               activeEP,
    output logic                     busy,
    output logic [CNT_W-1:0]         txCount,
    output logic [CNT_W-1:0]         rxCount,
    output logic                     txUnderrun,
    output logic                     rxOverrun,
    output logic                     badEP
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        sel_ep;
    logic              sel_ok;
    logic [DATA_W-1:0] sel_data;
    logic              sel_empty;
    logic              sel_full;
    logic              route;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_under;
    logic              wr_over;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; xferEnd takes priority over a stray xferStart in ACTIVE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xferStart) state_nxt = ACTIVE;
            ACTIVE:  if (xferEnd)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: IDLE previews currEndP, ACTIVE uses the latched endpoint
    always_comb begin
        busy      = (state == ACTIVE);
        sel_ep    = busy ? activeEP : currEndP;
        sel_ok    = busy ? ~badEP : ({1'b0, currEndP} < 5'(NUM_EP));
        sel_data  = '0;
        sel_empty = 1'b1;
        sel_full  = 1'b1;
        for (int i = 0; i < NUM_EP; i++) begin
            if (sel_ok && (sel_ep == 4'(i))) begin
                sel_data  = epTxData[i*DATA_W +: DATA_W];
                sel_empty = epTxEmpty[i];
                sel_full  = epRxFull[i];
            end
        end
        route    = busy && sel_ok && !rst;
        rd_ok    = route && TxFifoREn && !sel_empty;
        wr_ok    = route && RxFifoWEn && !sel_full;
        rd_under = route && TxFifoREn && sel_empty;
        wr_over  = route && RxFifoWEn && sel_full;
        epTxREn  = '0;
        epRxWEn  = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            epTxREn[i] = rd_ok && (sel_ep == 4'(i));
            epRxWEn[i] = wr_ok && (sel_ep == 4'(i));
        end
        TxFifoData  = sel_data;
        TxFifoEmpty = sel_empty;
        RxFifoFull  = sel_full;
    end

    // Per-transaction endpoint latch, saturating counters and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            activeEP   <= '0;
            txCount    <= '0;
            rxCount    <= '0;
            txUnderrun <= 1'b0;
            rxOverrun  <= 1'b0;
            badEP      <= 1'b0;
        end else if ((state == IDLE) && xferStart) begin
            activeEP   <= currEndP;
            txCount    <= '0;
            rxCount    <= '0;
            txUnderrun <= 1'b0;
            rxOverrun  <= 1'b0;
            badEP      <= ({1'b0, currEndP} >= 5'(NUM_EP));
        end else begin
            if (rd_ok && (txCount != CNT_MAX)) txCount <= txCount + CNT_W'(1);
            if (wr_ok && (rxCount != CNT_MAX)) rxCount <= rxCount + CNT_W'(1);
            if (rd_under) txUnderrun <= 1'b1;
            if (wr_over)  rxOverrun  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_ep_fifo_switch.sv
// Scoreboard bench for usb_ep_fifo_switch: a transaction-level model predicts every
// cycle's routing and status; a negedge monitor pops and compares.
module tb_usb_ep_fifo_switch;

    localparam int NUM_EP = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int SAT    = 2**CNT_W - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [3:0]               currEndP;
    logic                     xferStart;
    logic                     xferEnd;
    logic                     TxFifoREn;
    logic [DATA_W-1:0]        TxFifoData;
    logic                     TxFifoEmpty;
    logic                     RxFifoWEn;
    logic                     RxFifoFull;
    logic [NUM_EP-1:0]        epTxREn;
    logic [NUM_EP*DATA_W-1:0] epTxData;
    logic [NUM_EP-1:0]        epTxEmpty;
    logic [NUM_EP-1:0]        epRxWEn;
    logic [NUM_EP-1:0]        epRxFull;
    logic [3:0]               activeEP;
    logic                     busy;
    logic [CNT_W-1:0]         txCount;
    logic [CNT_W-1:0]         rxCount;
    logic                     txUnderrun;
    logic                     rxOverrun;
    logic                     badEP;

    usb_ep_fifo_switch #(.NUM_EP(NUM_EP), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .currEndP(currEndP), .xferStart(xferStart), .xferEnd(xferEnd),
        .TxFifoREn(TxFifoREn), .TxFifoData(TxFifoData), .TxFifoEmpty(TxFifoEmpty),
        .RxFifoWEn(RxFifoWEn), .RxFifoFull(RxFifoFull), .epTxREn(epTxREn), .epTxData(epTxData),
        .epTxEmpty(epTxEmpty), .epRxWEn(epRxWEn), .epRxFull(epRxFull), .activeEP(activeEP),
        .busy(busy), .txCount(txCount), .rxCount(rxCount), .txUnderrun(txUnderrun),
        .rxOverrun(rxOverrun), .badEP(badEP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_EP-1:0] ren;
        logic [NUM_EP-1:0] wen;
        logic [DATA_W-1:0] data;
        logic              empty;
        logic              full;
        bit                chk_data;
        bit                chk_reg;
        logic              busy;
        logic [3:0]        aep;
        logic [CNT_W-1:0]  txc;
        logic [CNT_W-1:0]  rxc;
        logic              und;
        logic              ovr;
        logic              bad;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level reference state
    bit m_active = 0;
    int m_ep = 0;
    int m_tx = 0;
    int m_rx = 0;
    bit m_und = 0;
    bit m_ovr = 0;
    bit m_bad = 0;

    // Drive one cycle of inputs, predict the DUT response, then advance the model
    task automatic cyc(input bit r, input int ep, input bit s, input bit e, input bit rd,
                       input bit wr, input logic [NUM_EP-1:0] txe, input logic [NUM_EP-1:0] rxf);
        exp_t x;
        int   sel;
        bit   ok;
        @(posedge clk);
        #1;
        rst = r; currEndP = 4'(ep); xferStart = s; xferEnd = e;
        TxFifoREn = rd; RxFifoWEn = wr; epTxData = $urandom; epTxEmpty = txe; epRxFull = rxf;
        sel = m_active ? m_ep : ep;
        ok  = sel < NUM_EP;
        x.data  = ok ? epTxData[sel*DATA_W +: DATA_W] : '0;
        x.empty = ok ? txe[sel] : 1'b1;
        x.full  = ok ? rxf[sel] : 1'b1;
        x.ren = '0;
        x.wen = '0;
        if (!r && m_active && ok && rd && !txe[sel]) x.ren[sel] = 1'b1;
        if (!r && m_active && ok && wr && !rxf[sel]) x.wen[sel] = 1'b1;
        x.chk_data = !r;
        x.chk_reg  = !r;
        x.busy = m_active; x.aep = 4'(m_ep); x.txc = CNT_W'(m_tx); x.rxc = CNT_W'(m_rx);
        x.und = m_und; x.ovr = m_ovr; x.bad = m_bad;
        q.push_back(x);
        if (r) begin
            m_active = 0; m_ep = 0; m_tx = 0; m_rx = 0; m_und = 0; m_ovr = 0; m_bad = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_ep = ep; m_tx = 0; m_rx = 0; m_und = 0; m_ovr = 0;
                m_bad = (ep >= NUM_EP);
            end
        end else begin
            if (ok && rd) begin
                if (!txe[sel]) m_tx = (m_tx < SAT) ? m_tx + 1 : SAT;
                else           m_und = 1;
            end
            if (ok && wr) begin
                if (!rxf[sel]) m_rx = (m_rx < SAT) ? m_rx + 1 : SAT;
                else           m_ovr = 1;
            end
            if (e) m_active = 0;
        end
    endtask

    // Monitor: one prediction is consumed per cycle, after inputs and outputs settle
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if ({epTxREn, epRxWEn} !== {x.ren, x.wen}) begin
                errors++;
                $display("FAIL enables: got tx=%b rx=%b, expected tx=%b rx=%b", epTxREn, epRxWEn, x.ren, x.wen);
            end
            if (x.chk_data) begin
                checks++;
                if ({TxFifoData, TxFifoEmpty, RxFifoFull} !== {x.data, x.empty, x.full}) begin
                    errors++;
                    $display("FAIL select: got data=%h empty=%b full=%b, expected data=%h empty=%b full=%b",
                             TxFifoData, TxFifoEmpty, RxFifoFull, x.data, x.empty, x.full);
                end
            end
            if (x.chk_reg) begin
                checks++;
                if ({busy, activeEP, txCount, rxCount, txUnderrun, rxOverrun, badEP} !==
                    {x.busy, x.aep, x.txc, x.rxc, x.und, x.ovr, x.bad}) begin
                    errors++;
                    $display("FAIL status: got busy=%b ep=%0d tx=%0d rx=%0d und=%b ovr=%b bad=%b, expected busy=%b ep=%0d tx=%0d rx=%0d und=%b ovr=%b bad=%b",
                             busy, activeEP, txCount, rxCount, txUnderrun, rxOverrun, badEP,
                             x.busy, x.aep, x.txc, x.rxc, x.und, x.ovr, x.bad);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; currEndP = '0; xferStart = 1'b0; xferEnd = 1'b0; TxFifoREn = 1'b0;
        RxFifoWEn = 1'b0; epTxData = '0; epTxEmpty = '1; epRxFull = '1;
        cyc(1, 0, 0, 0, 0, 0, 4'b1111, 4'b1111);
        cyc(1, 0, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 2, 0, 0, 0, 0, 4'b1010, 4'b0101);
        // Three reads on EP2
        cyc(0, 2, 1, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (3) cyc(0, 2, 0, 0, 1, 0, 4'b0000, 4'b0000);
        cyc(0, 2, 0, 1, 0, 0, 4'b0000, 4'b0000);
        cyc(0, 2, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // EP1 with currEndP moving to 3 mid-transaction
        cyc(0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (2) cyc(0, 3, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 3, 0, 1, 1, 0, 4'b0100, 4'b0000);
        // EP0 writes, third into a full FIFO
        cyc(0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (2) cyc(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0001);
        cyc(0, 0, 0, 1, 1, 0, 4'b0001, 4'b0001);
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Invalid endpoint
        cyc(0, 5, 1, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (2) cyc(0, 5, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 0, 0, 1, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Saturation, then a read in the xferEnd cycle; xferStart+xferEnd together in ACTIVE
        cyc(0, 2, 1, 0, 0, 0, 4'b0000, 4'b0000);
        repeat (5) cyc(0, 2, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 2, 1, 1, 1, 0, 4'b0000, 4'b0000);
        cyc(0, 2, 0, 1, 1, 1, 4'b0000, 4'b0000);
        // Reset during an active transaction with a strobe
        cyc(0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        cyc(0, 1, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(1, 1, 0, 0, 1, 1, 4'b0000, 4'b0000);
        cyc(0, 1, 0, 0, 1, 1, 4'b0000, 4'b0000);
        // Randomized traffic including invalid endpoints and occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        end
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
